// File: rtl/egg_timer_pkg.sv
// Shared types and constants for the egg timer datapath.
package egg_timer_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StAlarm = 2'd2
  } state_e;

  localparam int unsigned DigitW    = 4;
  localparam int unsigned AlarmCntW = 4;

  localparam logic [DigitW-1:0] DigitMax9 = 4'd9;
  localparam logic [DigitW-1:0] DigitMax5 = 4'd5;

  // Limit each preset digit to its legal maximum so the time register always holds valid BCD.
  function automatic logic [4*DigitW-1:0] clamp_preset(input logic [4*DigitW-1:0] p);
    logic [DigitW-1:0] mt, mo, st, so;
    mt = (p[15:12] > DigitMax9) ? DigitMax9 : p[15:12];
    mo = (p[11:8]  > DigitMax9) ? DigitMax9 : p[11:8];
    st = (p[7:4]   > DigitMax5) ? DigitMax5 : p[7:4];
    so = (p[3:0]   > DigitMax9) ? DigitMax9 : p[3:0];
    return {mt, mo, st, so};
  endfunction

endpackage

// File: rtl/bcd_digit_dec.sv
// One BCD digit of the borrow-chain decrementer; wraps 0 to MAX and borrows.
module bcd_digit_dec
  import egg_timer_pkg::*;
#(
  parameter logic [DigitW-1:0] MAX = DigitMax9
) (
  input  logic [DigitW-1:0] digit_i,
  input  logic              borrow_in_i,
  output logic [DigitW-1:0] digit_o,
  output logic              borrow_out_o
);

  // Decrement only when a borrow arrives from the less significant digit.
  always_comb begin
    digit_o      = digit_i;
    borrow_out_o = 1'b0;
    if (borrow_in_i) begin
      if (digit_i == '0) begin
        digit_o      = MAX;
        borrow_out_o = 1'b1;
      end else begin
        digit_o = digit_i - 1'b1;
      end
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// MM:SS BCD countdown with one-cycle done pulse and timed alarm level.
module countdown_timer
  import egg_timer_pkg::*;
#(
  parameter int unsigned ALARM_SECS = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] preset,
  input  logic        is_counting,
  input  logic        sec_clk,
  output logic [15:0] time_bcd,
  output logic        running,
  output logic        done,
  output logic        alarm,
  output logic        zero
);

  localparam logic [AlarmCntW-1:0] LastCnt = AlarmCntW'(ALARM_SECS - 1);

  state_e                 state_q, state_d;
  logic [15:0]            time_q, time_d;
  logic                   done_q, done_d;
  logic                   alarm_q, alarm_d;
  logic [AlarmCntW-1:0]   acnt_q, acnt_d;

  logic [15:0] dec_time;
  logic        b_so, b_st, b_mo, underflow;

  // Borrow chain: seconds ones always borrows, each digit passes its borrow upward.
  bcd_digit_dec #(.MAX(DigitMax9)) u_sec_ones (
    .digit_i      (time_q[3:0]),
    .borrow_in_i  (1'b1),
    .digit_o      (dec_time[3:0]),
    .borrow_out_o (b_so)
  );

  bcd_digit_dec #(.MAX(DigitMax5)) u_sec_tens (
    .digit_i      (time_q[7:4]),
    .borrow_in_i  (b_so),
    .digit_o      (dec_time[7:4]),
    .borrow_out_o (b_st)
  );

  bcd_digit_dec #(.MAX(DigitMax9)) u_min_ones (
    .digit_i      (time_q[11:8]),
    .borrow_in_i  (b_st),
    .digit_o      (dec_time[11:8]),
    .borrow_out_o (b_mo)
  );

  bcd_digit_dec #(.MAX(DigitMax9)) u_min_tens (
    .digit_i      (time_q[15:12]),
    .borrow_in_i  (b_mo),
    .digit_o      (dec_time[15:12]),
    .borrow_out_o (underflow)
  );

  // Next-state, time register and alarm bookkeeping.
  always_comb begin
    state_d = state_q;
    time_d  = time_q;
    done_d  = 1'b0;
    alarm_d = alarm_q;
    acnt_d  = acnt_q;
    unique case (state_q)
      StIdle: begin
        alarm_d = 1'b0;
        if (load) begin
          time_d = clamp_preset(preset);
        end else if (is_counting && (time_q != '0)) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (!is_counting) begin
          state_d = StIdle;
        end else if (sec_clk && !underflow) begin
          time_d = dec_time;
          // Last second elapsed: expire on this edge.
          if (dec_time == '0) begin
            done_d  = 1'b1;
            alarm_d = 1'b1;
            acnt_d  = '0;
            state_d = StAlarm;
          end
        end
      end
      StAlarm: begin
        if (load) begin
          time_d  = clamp_preset(preset);
          alarm_d = 1'b0;
          state_d = StIdle;
        end else if (sec_clk) begin
          if (acnt_q == LastCnt) begin
            alarm_d = 1'b0;
            state_d = StIdle;
          end else begin
            acnt_d = acnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        alarm_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      time_q  <= '0;
      done_q  <= 1'b0;
      alarm_q <= 1'b0;
      acnt_q  <= '0;
    end else begin
      state_q <= state_d;
      time_q  <= time_d;
      done_q  <= done_d;
      alarm_q <= alarm_d;
      acnt_q  <= acnt_d;
    end
  end

  // Outputs decoded from registers.
  always_comb begin
    time_bcd = time_q;
    running  = (state_q == StRun);
    done     = done_q;
    alarm    = alarm_q;
    zero     = (time_q == '0);
  end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Downstream consumer of controller_fsm in the egg timer datapath.
- Holds the user preset as 4 BCD digits (MM:SS).
- Decrements once per sec_clk pulse while is_counting is high.
- On reaching 00:00, emits a one-cycle done pulse, then holds a level alarm for a fixed number of seconds; the display driver and buzzer stages consume these outputs.

Parameters:
- ALARM_SECS, 5: number of sec_clk pulses the alarm output stays high after expiry (legal range 1..15).

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-high.
- load  input  1  capture preset into the time register; honoured only in IDLE and ALARM.
- preset  input  16  BCD preset {min_tens, min_ones, sec_tens, sec_ones}.
- is_counting  input  1  run-enable level from controller_fsm.
- sec_clk  input  1  one-clk-wide pulse per second from controller_fsm.
- time_bcd  output  16  current remaining time, registered BCD, same digit order as preset.
- running  output  1  high while state is RUN.
- done  output  1  one-cycle pulse on expiry.
- alarm  output  1  level, high throughout ALARM.
- zero  output  1  time_bcd == 16'h0000, decoded from the register.

Behaviour:
- Reset is asynchronous and active-high: rst forces state to IDLE and time_bcd, done and alarm to 0. running is 0 (IDLE) and zero is 1. This applies at any point, including mid-RUN or mid-ALARM.
- States are IDLE, RUN and ALARM. The state register and time_bcd update on the rising edge of clk.
- Preset clamping at load: min_tens and min_ones greater than 9 become 9; sec_tens greater than 5 becomes 5; sec_ones greater than 9 becomes 9. Loaded values are therefore always legal BCD in the range 00:00 to 99:59.
- IDLE:
  - load=1: time_bcd takes the clamped preset on the next edge; state stays IDLE.
  - load=0, is_counting=1, time_bcd != 0: go to RUN.
  - is_counting=1 with time_bcd == 0: stay in IDLE; no done, no alarm.
  - sec_clk is ignored.
- RUN:
  - is_counting=0: go to IDLE with time_bcd held (pause). A sec_clk in that same cycle does NOT decrement.
  - sec_clk=1 and is_counting=1: decrement by 1 s, visible on time_bcd one clk after the sampled pulse.
  - Decrement borrows digit by digit:
    - sec_ones 0 goes to 9 and borrows from sec_tens.
    - sec_tens 0 goes to 5 and borrows from min_ones.
    - min_ones 0 goes to 9 and borrows from min_tens.
  - Decrement 00:01 to 00:00: in the same edge, done=1 for exactly one cycle, alarm=1 and state goes to ALARM.
  - load is ignored in RUN.
- ALARM:
  - alarm=1; time_bcd holds 0000.
  - An internal counter, reset to 0 on entry, increments on each sec_clk pulse regardless of is_counting.
  - On the ALARM_SECS-th pulse: alarm=0 and state goes to IDLE on that edge.
  - load=1 in ALARM acknowledges the alarm: alarm=0, preset captured, state goes to IDLE on the same edge. load has priority over a simultaneous sec_clk.
- 00:00 is never decremented; there is no wrap to 99:59.
- running is registered with the state (running = state==RUN).

Decomposition:
- Shared egg_timer_pkg include holds:
  - state encodings IDLE/RUN/ALARM;
  - BCD digit width 4;
  - digit maxima 9 and 5;
  - alarm counter width 4.
- One sub-module, bcd_digit_dec, parameterised by MAX (9 or 5):
  - inputs: digit, borrow_in;
  - outputs: next digit, borrow_out.
- countdown_timer instantiates four bcd_digit_dec in a borrow chain.

Test Plan:
1. Load preset 16'h0102, set is_counting=1, apply 3 sec_clk pulses. time_bcd must read 0101, 0100, 0059, each change exactly 1 clk after its pulse; running=1 throughout.
2. Preset 16'h1000, one pulse. time_bcd must read 0959, confirming borrow across every digit.
3. Preset 16'h0002, ALARM_SECS=3, two pulses.
   - time_bcd reads 0000 with done high for exactly 1 cycle and alarm rising the same cycle.
   - alarm falls on the 3rd subsequent pulse and state returns to IDLE.
   - Further pulses leave 0000 unchanged.
4. In RUN at 0030, drop is_counting in the same cycle as sec_clk. time_bcd must stay 0030 and running go to 0; re-raising is_counting resumes, giving 0029 on the next pulse.
5. Preset 16'hAB7F must load as 9959. While in ALARM, load 0010: alarm drops and time_bcd reads 0010 on the same edge.
6. Assert rst asynchronously (between clock edges) mid-RUN at 0045. time_bcd=0000, running=0, alarm=0 and zero=1 must all appear immediately, without waiting for a clk edge.
